ren_result_pack: RTL and testbench
==================================

# ren_result_pack

Result drain and requantisation stage that sits directly downstream of the convolution engine's result RAM. After a convolution completes, it reads the signed 20-bit accumulator results sequentially, optionally applies ReLU, and arithmetic-shifts and saturates each value to signed 8-bit. It packs four results per 32-bit word and emits the words on a valid/ready stream toward the next layer's image loader or a Wishbone-side FIFO.

## Interface
Parameters:
- RSLT_ADDR_WIDTH, 6: result RAM address width.
- RSLT_DWIDTH, 20: result word width (signed two's complement).
- CNT_WIDTH, 7: width of `count`; must hold 2^RSLT_ADDR_WIDTH.

Ports (one clock; reset is asynchronous and active-low):
- wb_clk_i  in  1  sole clock; all state updates on its rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; sampled only in IDLE.
- count  in  CNT_WIDTH  number of results to drain, 0..64; sampled with `start`.
- shift  in  4  arithmetic right-shift amount, 0..15; sampled with `start`.
- relu_en  in  1  clamp negatives to 0 before shifting; sampled with `start`.
- rd_en  out  1  result RAM read strobe.
- rd_addr  out  RSLT_ADDR_WIDTH  result RAM read address.
- rd_data  in  RSLT_DWIDTH  read data, valid the cycle after `rd_en`.
- out_valid  out  1  packed word available.
- out_ready  in  1  consumer accepts the word when `out_valid & out_ready`.
- out_data  out  32  packed bytes, result n at bits [8*(n%4)+7 : 8*(n%4)].
- out_last  out  1  qualifies the final word of a drain.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse when a drain finishes.
- sat_cnt  out  CNT_WIDTH  count of results saturated in the current or last drain.

## Operation
- FSM states: IDLE, FETCH, CAPTURE, OUT, FIN.
- IDLE: on `start` with count≠0, latch count/shift/relu_en, clear sat_cnt, clear the pack register, set index=0, and go to FETCH. On `start` with count=0, clear sat_cnt and go to FIN. `start` is ignored in every other state.
- FETCH: drive rd_en=1 and rd_addr=index for one cycle, then go to CAPTURE.
- CAPTURE: compute v = rd_data (signed). If relu_en and v<0, v=0. Then v = v >>> shift (floor; no rounding). Saturate to [-128,127]; increment sat_cnt if clamped (sat_cnt does not wrap, max 64). Write the byte to lane index%4 and increment index.
  - If index%4 was 3, or index+1 == count, go to OUT.
  - Otherwise go to FETCH.
- OUT: out_valid=1. out_data and out_last are held stable until the handshake. Unfilled lanes of a partial final word are 0x00. out_last=1 iff index==count. On handshake, clear the pack register; go to FIN if out_last, else FETCH.
- FIN: done=1 for this cycle only, then go to IDLE.
- rd_addr wraps naturally at 64; count=64 reads addresses 0..63 exactly once.

## Timing
- Reset values:
  - Outputs: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, sat_cnt=0.
  - Internal: state=IDLE.
- Asserting reset mid-drain aborts immediately. There is no done pulse, and any partial word is discarded.
- Throughput: 2 cycles per result plus ≥1 cycle per word in OUT.
- With start sampled at edge 0 and out_ready held high:
  - The first rd_en is high in cycle 1.
  - The first out_valid is high in cycle 9.
  - The handshake occurs in cycle 9.
- Worked example for count=4: done is high in cycle 10, busy drops after cycle 10, and a new start is accepted from cycle 11.
- count=0: done is high in the cycle after start. No rd_en and no out_valid occur.
- Backpressure: while out_ready=0 in OUT, no reads are issued and all outputs are held constant.
- out_valid never depends combinationally on out_ready.
- All outputs are registered.

## Test plan
- Reset, then start with count=4, shift=0, relu_en=0, RAM[0..3]={1,-1,127,-128}, out_ready=1:
  - One word 0x807FFF01 with out_last=1, first valid in cycle 9.
  - done in cycle 10, sat_cnt=0.
- count=6, shift=4, relu_en=1, RAM[0..5]={0x00100, -0x00100, 0x7FFFF, 0x00050, 0x00030, -5}:
  - Words 0x057F0010 then 0x00000003 (out_last=1, upper lanes 0).
  - sat_cnt=1.
- count=64 with RAM[i]=i and random out_ready stalls:
  - 16 words, bytes 0..63 in order, data stable across every stall.
  - out_last only on word 16, no rd_en during stalls.
- start with count=0: done exactly one cycle later, rd_en and out_valid never asserted. A second start pulse while busy is ignored.
- Reset asserted in cycle 5 of a count=8 drain:
  - All outputs reach reset values asynchronously.
  - A subsequent start drains correctly from address 0.

Source files
------------

// File: rtl/ren_result_pack.sv
// Result drain/requantise: reads 20-bit results, optional ReLU, >>> shift, saturate to int8, packs 4 per word.
// Latency: 2 cycles per result (FETCH, CAPTURE) plus >=1 cycle per packed word in OUT; all outputs registered.
// Backpressure: while OUT waits on out_ready, no reads are issued and every output is held constant.
module ren_result_pack #(
  parameter int RSLT_ADDR_WIDTH = 6,
  parameter int RSLT_DWIDTH     = 20,
  parameter int CNT_WIDTH       = 7
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       count,
  input  logic [3:0]                 shift,
  input  logic                       relu_en,
  output logic                       rd_en,
  output logic [RSLT_ADDR_WIDTH-1:0] rd_addr,
  input  logic [RSLT_DWIDTH-1:0]     rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       sat_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUT     = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  localparam logic signed [RSLT_DWIDTH-1:0] SAT_MAX = RSLT_DWIDTH'(127);
  localparam logic signed [RSLT_DWIDTH-1:0] SAT_MIN = -(RSLT_DWIDTH'(128));

  state_t                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [3:0]                 shift_q, shift_d;
  logic                       relu_q, relu_d;
  logic [CNT_WIDTH-1:0]       idx_q, idx_d;
  logic [31:0]                pack_q, pack_d;
  logic [CNT_WIDTH-1:0]       sat_q, sat_d;
  logic                       rd_en_q, rd_en_d;
  logic [RSLT_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                          hs;
  logic                          last_idx;
  logic signed [RSLT_DWIDTH-1:0] v_relu;
  logic signed [RSLT_DWIDTH-1:0] v_shift;
  logic [7:0]                    byte_val;
  logic                          clamp;

  assign hs       = (state_q == S_OUT) && out_ready;
  // The result being captured is the last of the drain.
  assign last_idx = ((idx_q + CNT_WIDTH'(1)) == cnt_q);

  // Requantise the returning RAM word: ReLU, floor shift, clamp to int8.
  always_comb begin
    v_relu = $signed(rd_data);
    if (relu_q && v_relu[RSLT_DWIDTH-1]) begin
      v_relu = '0;
    end
    v_shift  = v_relu >>> shift_q;
    byte_val = v_shift[7:0];
    clamp    = 1'b0;
    if (v_shift > SAT_MAX) begin
      byte_val = 8'h7F;
      clamp    = 1'b1;
    end else if (v_shift < SAT_MIN) begin
      byte_val = 8'h80;
      clamp    = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (count == '0) ? S_FIN : S_FETCH;
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = ((idx_q[1:0] == 2'd3) || last_idx) ? S_OUT : S_FETCH;
      S_OUT:     if (out_ready) state_d = out_last_q ? S_FIN : S_FETCH;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values, derived from the state being entered.
  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    idx_d       = idx_q;
    pack_d      = pack_q;
    sat_d       = sat_q;
    out_last_d  = out_last_q;
    rd_addr_d   = rd_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sat_d      = '0;
          out_last_d = 1'b0;
          if (count != '0) begin
            cnt_d   = count;
            shift_d = shift;
            relu_d  = relu_en;
            idx_d   = '0;
            pack_d  = '0;
          end
        end
      end
      S_CAPTURE: begin
        pack_d[{idx_q[1:0], 3'b000} +: 8] = byte_val;
        if (clamp && (sat_q != '1)) begin
          sat_d = sat_q + CNT_WIDTH'(1);
        end
        idx_d      = idx_q + CNT_WIDTH'(1);
        out_last_d = last_idx;
      end
      S_OUT: begin
        if (hs) begin
          pack_d     = '0;
          out_last_d = 1'b0;
        end
      end
      default: ;
    endcase

    rd_en_d     = (state_d == S_FETCH);
    if (state_d == S_FETCH) begin
      rd_addr_d = idx_d[RSLT_ADDR_WIDTH-1:0];
    end
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
  end

  // State, datapath and output registers; reset aborts any drain in progress.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      idx_q       <= '0;
      pack_q      <= '0;
      sat_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      idx_q       <= idx_d;
      pack_q      <= pack_d;
      sat_q       <= sat_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = pack_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sat_cnt   = sat_q;

endmodule

// File: tb/tb_ren_result_pack.sv
// Bench for ren_result_pack: random drains against a floor-division int8 model, scoreboard queue of packed words.
// Stimulus and checking are decoupled; a negedge monitor pops expected words on every handshake.
// Covers reset values, worked timing, ReLU/saturation, stalls, count=0, ignored restart, mid-drain reset.
module tb_ren_result_pack;
  localparam int AW = 6;
  localparam int DW = 20;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic [3:0]    shift = '0;
  logic          relu_en = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] sat_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;

  logic [DW-1:0] ram [64];
  logic [32:0]   exp_q[$];
  int            exp_sat;
  int            first_valid, first_hs, done_cyc, rd_cnt, ov_cnt, done_cnt;
  bit            stall_mode = 1'b0;
  bit            prev_stall = 1'b0;
  logic [32:0]   prev_word;

  ren_result_pack #(.RSLT_ADDR_WIDTH(AW), .RSLT_DWIDTH(DW), .CNT_WIDTH(CW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .start(start), .count(count), .shift(shift),
    .relu_en(relu_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .sat_cnt(sat_cnt)
  );

  initial forever begin
    #5 cyc++; clk = 1'b1;
    #5 clk = 1'b0;
  end

  // Result RAM: synchronous read, data the cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  initial forever begin
    @(posedge clk);
    #1 out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requantise one result: ReLU, floor(v / 2^sh), clamp. Returns {saturated, byte}.
  function automatic logic [8:0] model_byte(logic [DW-1:0] raw, int sh, bit relu);
    int v;
    int d;
    bit s;
    logic [31:0] vb;
    v = $signed(raw);
    if (relu && v < 0) v = 0;
    d = 1 << sh;
    if (v >= 0) v = v / d;
    else        v = -(((-v) + d - 1) / d);
    s = 1'b0;
    if (v > 127)       begin v = 127;  s = 1'b1; end
    else if (v < -128) begin v = -128; s = 1'b1; end
    vb = v;
    return {s, vb[7:0]};
  endfunction

  task automatic push_expected(int n, int sh, bit relu);
    logic [31:0] w;
    logic [8:0]  r;
    w = '0;
    exp_sat = 0;
    for (int i = 0; i < n; i++) begin
      r = model_byte(ram[i], sh, relu);
      exp_sat += int'(r[8]);
      w[8*(i%4) +: 8] = r[7:0];
      if ((i % 4 == 3) || (i == n - 1)) begin
        exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, w});
        w = '0;
      end
    end
  endtask

  task automatic clear_stats();
    first_valid = -1; first_hs = -1; done_cyc = -1;
    rd_cnt = 0; ov_cnt = 0; done_cnt = 0;
  endtask

  // Monitor: scoreboard pop on handshake, stall stability, no reads while stalled.
  always @(negedge clk) begin
    int rel;
    logic [32:0] e;
    rel = cyc - t0 + 1;
    if (rst_n) begin
      if (rd_en) rd_cnt++;
      if (prev_stall) check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
      if (out_valid) begin
        ov_cnt++;
        if (first_valid < 0) first_valid = rel;
        if (!out_ready) check("rd_during_stall", rd_en, 0);
        if (out_ready) begin
          if (first_hs < 0) first_hs = rel;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %0h expected none", {out_last, out_data});
          end else begin
            e = exp_q.pop_front();
            check("word", {out_last, out_data}, e);
          end
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = rel;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_reset(string tag);
    check({tag, "_rd_en"},     rd_en, 0);
    check({tag, "_rd_addr"},   rd_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_sat_cnt"},   sat_cnt, 0);
  endtask

  task automatic issue_start(int n, int sh, bit relu);
    @(posedge clk);
    #1 start = 1'b1; count = CW'(n); shift = 4'(sh); relu_en = relu;
    @(posedge clk);
    t0 = cyc;
    #1 start = 1'b0; count = CW'($urandom); shift = 4'($urandom); relu_en = 1'($urandom);
  endtask

  task automatic run_drain(string tag, int n, int sh, bit relu, bit stalls, bit poke);
    push_expected(n, sh, relu);
    clear_stats();
    stall_mode = stalls;
    issue_start(n, sh, relu);
    if (poke) begin
      @(posedge clk);
      #1 start = 1'b1; count = CW'(2);
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cyc < 0; k++) @(posedge clk);
    check({tag, "_done_seen"}, (done_cyc >= 0), 1);
    stall_mode = 1'b0;
    @(negedge clk);
    check({tag, "_sat_cnt"}, sat_cnt, exp_sat);
    check({tag, "_words_left"}, exp_q.size(), 0);
    check({tag, "_rd_cnt"}, rd_cnt, n);
    repeat (4) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle"}, busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    #23;
    check_reset("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Worked example: bytes 01 FF 7F 80, timing from the start edge.
    ram[0] = 20'h00001; ram[1] = 20'hFFFFF; ram[2] = 20'h0007F; ram[3] = 20'hFFF80;
    exp_q.push_back({1'b1, 32'h807FFF01});
    clear_stats();
    issue_start(4, 0, 1'b0);
    for (int k = 0; k < 50 && done_cyc < 0; k++) @(posedge clk);
    @(negedge clk);
    check("t1_first_valid_cyc", first_valid, 9);
    check("t1_handshake_cyc", first_hs, 9);
    check("t1_done_cyc", done_cyc, 10);
    check("t1_sat_cnt", sat_cnt, 0);
    check("t1_words_left", exp_q.size(), 0);
    check("t1_busy_after", busy, 0);

    // ReLU, shift 4, one saturation, partial final word.
    ram[0] = 20'h00100; ram[1] = 20'hFFF00; ram[2] = 20'h7FFFF;
    ram[3] = 20'h00050; ram[4] = 20'h00030; ram[5] = 20'hFFFFB;
    exp_q.push_back({1'b0, 32'h057F0010});
    exp_q.push_back({1'b1, 32'h00000003});
    clear_stats();
    issue_start(6, 4, 1'b1);
    for (int k = 0; k < 100 && done_cyc < 0; k++) @(posedge clk);
    @(negedge clk);
    check("t2_sat_cnt", sat_cnt, 1);
    check("t2_words_left", exp_q.size(), 0);

    // Full 64-entry drain with random stalls.
    for (int i = 0; i < 64; i++) ram[i] = DW'(i);
    run_drain("full64", 64, 0, 1'b0, 1'b1, 1'b0);
    check("full64_words", ov_cnt >= 16, 1);

    // count = 0: done next cycle, no reads, no words.
    run_drain("zero", 0, 0, 1'b0, 1'b0, 1'b0);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_out_valid", ov_cnt, 0);

    // Restart pulse while busy must be ignored.
    for (int i = 0; i < 64; i++) ram[i] = DW'($urandom);
    run_drain("restart", 4, 3, 1'b0, 1'b0, 1'b1);

    // Random drains against the model.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 64; i++) ram[i] = DW'($urandom);
      n = $urandom_range(1, 64);
      run_drain("rand", n, $urandom_range(0, 15), 1'($urandom), 1'b1, 1'b0);
    end

    // Reset in cycle 5 of a count=8 drain, then a clean drain from address 0.
    for (int i = 0; i < 64; i++) ram[i] = DW'($urandom);
    clear_stats();
    issue_start(8, 2, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("midreset");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    run_drain("after_reset", 8, 2, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
